// File: rtl/donut_march.sv
// Ray-march sequencer: steps a sample point along a ray through the torus distance path.
// Optional DONUT_MARCH_SHADE_EN keeps the shade capture register; otherwise shade is tied to 0.
module donut_march #(
  parameter int unsigned        MAX_STEPS  = 8,
  parameter logic signed [15:0] HIT_THRESH = 16'sd8,
  parameter logic [16:0]        FAR_LIMIT  = 17'h04000,
  parameter int unsigned        FRAC       = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [15:0] ox,
  input  logic signed [15:0] oy,
  input  logic signed [15:0] oz,
  input  logic signed [15:0] dx,
  input  logic signed [15:0] dy,
  input  logic signed [15:0] dz,
  output logic signed [15:0] px,
  output logic signed [15:0] py,
  output logic signed [15:0] pz,
  input  logic signed [15:0] sdf_dist,
  input  logic signed [15:0] sdf_shade,
  output logic               busy,
  output logic               done,
  output logic               hit,
  output logic [3:0]         steps,
  output logic signed [15:0] shade
);

  localparam int unsigned TW = 17;
  localparam int unsigned SW = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MARCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]         state, state_nxt;
  logic signed [15:0] dir_x, dir_y, dir_z;
  logic [TW-1:0]      t, t_nxt;
  logic [SW-1:0]      step, step_nxt;
  logic signed [15:0] px_nxt, py_nxt, pz_nxt;
  logic               hit_nxt;
  logic [SW-1:0]      steps_nxt;
  logic               accept;
  logic               take_hit;
  logic signed [18:0] tsum;

  // One axis advance: p + (d*dir >>> FRAC), saturated to the 16-bit signed range.
  function automatic logic signed [15:0] advance(input logic signed [15:0] p,
                                                 input logic signed [15:0] dd,
                                                 input logic signed [15:0] dir);
    logic signed [31:0] prod;
    logic signed [31:0] delta;
    logic signed [32:0] sum;
    prod  = 32'(dd) * 32'(dir);
    delta = prod >>> FRAC;
    sum   = 33'(p) + 33'(delta);
    if (sum > 33'sd32767)       return 16'sh7fff;
    else if (sum < -33'sd32768) return 16'sh8000;
    else                        return sum[15:0];
  endfunction

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    px_nxt    = px;
    py_nxt    = py;
    pz_nxt    = pz;
    t_nxt     = t;
    step_nxt  = step;
    hit_nxt   = hit;
    steps_nxt = steps;
    accept    = 1'b0;
    take_hit  = 1'b0;
    tsum      = $signed({2'b00, t}) + 19'(sdf_dist);
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          px_nxt    = ox;
          py_nxt    = oy;
          pz_nxt    = oz;
          t_nxt     = '0;
          step_nxt  = '0;
          hit_nxt   = 1'b0;
          steps_nxt = '0;
          state_nxt = ST_MARCH;
        end
      end
      ST_MARCH: begin
        if (sdf_dist < HIT_THRESH) begin
          take_hit  = 1'b1;
          hit_nxt   = 1'b1;
          steps_nxt = step;
          state_nxt = ST_DONE;
        end else if (step == SW'(MAX_STEPS - 1)) begin
          steps_nxt = step;
          state_nxt = ST_DONE;
        end else if (tsum > $signed({2'b00, FAR_LIMIT})) begin
          steps_nxt = step;
          state_nxt = ST_DONE;
        end else begin
          px_nxt   = advance(px, sdf_dist, dir_x);
          py_nxt   = advance(py, sdf_dist, dir_y);
          pz_nxt   = advance(pz, sdf_dist, dir_z);
          t_nxt    = tsum[TW-1:0];
          step_nxt = step + SW'(1);
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, point, ray length and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      px    <= '0;
      py    <= '0;
      pz    <= '0;
      dir_x <= '0;
      dir_y <= '0;
      dir_z <= '0;
      t     <= '0;
      step  <= '0;
      hit   <= 1'b0;
      steps <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      px    <= px_nxt;
      py    <= py_nxt;
      pz    <= pz_nxt;
      t     <= t_nxt;
      step  <= step_nxt;
      hit   <= hit_nxt;
      steps <= steps_nxt;
      busy  <= (state_nxt == ST_MARCH);
      done  <= (state_nxt == ST_DONE);
      if (accept) begin
        dir_x <= dx;
        dir_y <= dy;
        dir_z <= dz;
      end
    end
  end

`ifdef DONUT_MARCH_SHADE_EN
  // Shade is cleared on a new ray and captured on the hit step only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        shade <= '0;
    else if (accept)   shade <= '0;
    else if (take_hit) shade <= sdf_shade;
  end
`else
  logic unused_shade;
  assign unused_shade = ^{sdf_shade, take_hit};
  assign shade = '0;
`endif

endmodule

// File: tb/tb_donut_march.sv
// Bench for donut_march: vector table of rays against a behavioural SDF, scoreboarded results.
module tb_donut_march;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic signed [15:0] ox, oy, oz, dx, dy, dz;
  logic signed [15:0] px, py, pz;
  logic signed [15:0] sdf_dist, sdf_shade;
  logic               busy, done, hit;
  logic [3:0]         steps;
  logic signed [15:0] shade;

  donut_march dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ox(ox), .oy(oy), .oz(oz), .dx(dx), .dy(dy), .dz(dz),
    .px(px), .py(py), .pz(pz),
    .sdf_dist(sdf_dist), .sdf_shade(sdf_shade),
    .busy(busy), .done(done), .hit(hit), .steps(steps), .shade(shade)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SDF environment: 0 = plane (c - px), 1 = constant c, 2 = c at origin x else h.
  int m_mode, m_c, m_h, m_sh, m_ox;
  always_comb begin
    case (m_mode)
      0:       sdf_dist = 16'(m_c - int'(px));
      1:       sdf_dist = 16'(m_c);
      default: sdf_dist = (int'(px) == m_ox) ? 16'(m_c) : 16'(m_h);
    endcase
    sdf_shade = 16'(m_sh);
  end

  typedef struct {
    int mode;
    int ox, oy, oz, dx, dy, dz;
    int c, h, sh;
    int e_hit, e_steps, e_px, e_py, e_pz, e_lat;
  } vec_t;

  typedef struct {
    int hit, steps, shade, px, py, pz, lat;
  } exp_t;

  vec_t vt[9];
  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_ray(input int i, input bit poke);
    exp_t e;
    int   cyc;
    bit   got;
    m_mode = vt[i].mode; m_c = vt[i].c; m_h = vt[i].h; m_sh = vt[i].sh; m_ox = vt[i].ox;
    ox = 16'(vt[i].ox); oy = 16'(vt[i].oy); oz = 16'(vt[i].oz);
    dx = 16'(vt[i].dx); dy = 16'(vt[i].dy); dz = 16'(vt[i].dz);
    e.hit = vt[i].e_hit; e.steps = vt[i].e_steps;
    e.px = vt[i].e_px; e.py = vt[i].e_py; e.pz = vt[i].e_pz; e.lat = vt[i].e_lat;
`ifdef DONUT_MARCH_SHADE_EN
    e.shade = vt[i].e_hit ? vt[i].sh : 0;
`else
    e.shade = 0;
`endif
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble the ray inputs so only the captured copies can matter.
    ox = 16'($urandom); oy = 16'($urandom); oz = 16'($urandom);
    dx = 16'($urandom); dy = 16'($urandom); dz = 16'($urandom);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk($sformatf("v%0d_busy", i), int'(busy), 1);
      start = poke && (cyc == 3);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL v%0d_timeout: no done within %0d cycles", i, cyc);
      void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL v%0d_sb: done with empty scoreboard", i);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d_lat", i),   cyc,          e.lat);
      chk($sformatf("v%0d_hit", i),   int'(hit),    e.hit);
      chk($sformatf("v%0d_steps", i), int'(steps),  e.steps);
      chk($sformatf("v%0d_shade", i), int'(shade),  e.shade);
      chk($sformatf("v%0d_px", i),    int'(px),     e.px);
      chk($sformatf("v%0d_py", i),    int'(py),     e.py);
      chk($sformatf("v%0d_pz", i),    int'(pz),     e.pz);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), int'(done),  0);
      chk($sformatf("v%0d_idle_busy", i),  int'(busy),  0);
      chk($sformatf("v%0d_hit_hold", i),   int'(hit),   e.hit);
      chk($sformatf("v%0d_steps_hold", i), int'(steps), e.steps);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_px"},    int'(px),    0);
    chk({tag, "_py"},    int'(py),    0);
    chk({tag, "_pz"},    int'(pz),    0);
    chk({tag, "_busy"},  int'(busy),  0);
    chk({tag, "_done"},  int'(done),  0);
    chk({tag, "_hit"},   int'(hit),   0);
    chk({tag, "_steps"}, int'(steps), 0);
    chk({tag, "_shade"}, int'(shade), 0);
  endtask

  initial begin
    //        mode ox      oy oz  dx     dy     dz     c       h   sh        hit st px      py    pz   lat
    vt[0] = '{0,   0,      0, 0,  4096,  0,     0,     1000,   0,  'h0777,   1,  1, 1000,   0,    0,   3};
    vt[1] = '{1,   0,      0, 0,  4096,  0,     0,     100,    0,  'h0555,   0,  7, 700,    0,    0,   9};
    vt[2] = '{1,   0,      0, 0,  4096,  0,     0,     'h3000, 0,  0,        0,  1, 'h3000, 0,    0,   3};
    vt[3] = '{1,   5,     -7, 9,  4096,  0,     0,     -50,    0,  'h1234,   1,  0, 5,      -7,   9,   2};
    vt[4] = '{2,   32000,  0, 0,  4096,  0,     0,     1000,   -1, 'h0abc,   1,  1, 32767,  0,    0,   3};
    vt[5] = '{2,  -32000,  0, 0, -4096,  2048, -2048,  1000,   -1, 'h7001,   1,  1, -32768, 500, -500, 3};
    vt[6] = '{2,   0,      0, 0,  4096,  0,     0,     8,      7,  'h0042,   1,  1, 8,      0,    0,   3};
    vt[7] = '{1,   0,      0, 0,  4096,  0,     0,     'h2000, 0,  0,        0,  2, 'h4000, 0,    0,   4};
    vt[8] = '{1,   0,      0, 0,  2048, -1024,  0,     100,    0,  'h0111,   0,  7, 350,   -175,  0,   9};

    rst_n = 1'b0; start = 1'b0;
    ox = '0; oy = '0; oz = '0; dx = '0; dy = '0; dz = '0;
    m_mode = 1; m_c = 100; m_h = 0; m_sh = 0; m_ox = 0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_ray(i, 1'b0);

    // Start pulsed mid-march must not disturb the ray in flight.
    run_ray(1, 1'b1);

    // Reset in the middle of a march clears everything immediately.
    m_mode = 1; m_c = 100; m_sh = 'h0555;
    ox = 16'sd10; oy = '0; oz = '0; dx = 16'sd4096; dy = '0; dz = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_ray(0, 1'b0);
    run_ray(3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
